// File: rtl/cam_i2c_arbiter.sv
// rtl/cam_i2c_arbiter.sv - round-robin owner arbitration, watchdog and pad mux for the shared camera I2C bus
module cam_i2c_arbiter #(
  parameter int N_REQ          = 3,
  parameter int TIMEOUT_CYCLES = 500000,
  parameter int GAP_CYCLES     = 250
) (
  input  logic             iCLK,
  input  logic             iRST,
  input  logic [N_REQ-1:0] iREQ,
  input  logic [N_REQ-1:0] iDONE,
  input  logic [N_REQ-1:0] iSCL_M,
  input  logic [N_REQ-1:0] iSDA_OE_M,
  output logic [N_REQ-1:0] oGRANT,
  output logic             oSCL,
  output logic             oSDA_OE,
  output logic             oBUSY,
  output logic             oTIMEOUT,
  output logic [2:0]       oTIMEOUT_ID
);

  localparam int IW    = $clog2(N_REQ);
  localparam int WD_W  = $clog2(TIMEOUT_CYCLES + 1);
  localparam int GAP_W = $clog2(GAP_CYCLES + 1);

  localparam logic [WD_W-1:0]  WD_LAST  = WD_W'(TIMEOUT_CYCLES - 1);
  localparam logic [WD_W-1:0]  WD_MAX   = WD_W'(TIMEOUT_CYCLES);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);
  localparam logic [GAP_W-1:0] GAP_MAX  = GAP_W'(GAP_CYCLES);
  localparam logic [IW-1:0]    LAST_RST = IW'(N_REQ - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_GRANT, ST_GAP} state_t;

  state_t           state, state_d;
  logic [IW-1:0]    owner, last, win_idx;
  logic             win_found;
  logic [N_REQ-1:0] mask, mask_d, eligible;
  logic [WD_W-1:0]  wd_cnt;
  logic [GAP_W-1:0] gap_cnt;
  logic             own_done, own_drop, expire, grant_end;
  int               cand;

  assign eligible = iREQ & ~mask;
  assign oBUSY    = (state != ST_IDLE);

  // Search upward from the index after the last winner, wrapping once.
  always_comb begin
    win_found = 1'b0;
    win_idx   = last;
    cand      = 0;
    for (int k = 1; k <= N_REQ; k++) begin
      cand = int'(last) + k;
      if (cand >= N_REQ) cand = cand - N_REQ;
      if (!win_found && eligible[IW'(cand)]) begin
        win_found = 1'b1;
        win_idx   = IW'(cand);
      end
    end
  end

  always_comb begin
    state_d   = state;
    own_done  = 1'b0;
    own_drop  = 1'b0;
    expire    = 1'b0;
    grant_end = 1'b0;
    mask_d    = mask & iREQ;
    case (state)
      ST_IDLE: if (win_found) state_d = ST_GRANT;
      ST_GRANT: begin
        own_done  = iDONE[owner];
        own_drop  = !iREQ[owner];
        // A clean finish in the last allowed cycle is not a revocation.
        expire    = (wd_cnt == WD_LAST) && !own_done && !own_drop;
        grant_end = own_done || own_drop || expire;
        if (grant_end) state_d = ST_GAP;
        if (expire) mask_d[owner] = 1'b1;
      end
      ST_GAP: if (gap_cnt == GAP_LAST) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      state       <= ST_IDLE;
      owner       <= '0;
      last        <= LAST_RST;
      mask        <= '0;
      wd_cnt      <= '0;
      gap_cnt     <= '0;
      oGRANT      <= '0;
      oSCL        <= 1'b1;
      oSDA_OE     <= 1'b0;
      oTIMEOUT    <= 1'b0;
      oTIMEOUT_ID <= '0;
    end else begin
      state    <= state_d;
      mask     <= mask_d;
      oTIMEOUT <= expire;
      if (expire) oTIMEOUT_ID <= 3'(owner);
      // The pad follows the owner one cycle late and is released as soon as the grant ends.
      if (state == ST_GRANT && !grant_end) begin
        oSCL    <= iSCL_M[owner];
        oSDA_OE <= iSDA_OE_M[owner];
      end else begin
        oSCL    <= 1'b1;
        oSDA_OE <= 1'b0;
      end
      case (state)
        ST_IDLE: begin
          if (win_found) begin
            owner  <= win_idx;
            last   <= win_idx;
            oGRANT <= N_REQ'(1) << win_idx;
            wd_cnt <= '0;
          end
        end
        ST_GRANT: begin
          if (grant_end) begin
            oGRANT  <= '0;
            gap_cnt <= '0;
          end else if (wd_cnt != WD_MAX) begin
            wd_cnt <= wd_cnt + WD_W'(1);
          end
        end
        ST_GAP: begin
          if (gap_cnt != GAP_MAX) gap_cnt <= gap_cnt + GAP_W'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cam_i2c_arbiter.sv
// tb/tb_cam_i2c_arbiter.sv - directed and randomized checks of cam_i2c_arbiter against a cycle reference model
module tb_cam_i2c_arbiter;
  localparam int N   = 3;
  localparam int TMO = 100;
  localparam int GAP = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] req, done, scl_m, sda_m;
  logic [N-1:0] grant;
  logic         scl, sda_oe, busy, tmo;
  logic [2:0]   tmo_id;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  int n;
  logic v;

  int           m_owner, m_held, m_gap, m_last;
  logic [N-1:0] m_mask, e_grant;
  logic         e_scl, e_sda, e_busy, e_tmo;
  logic [2:0]   e_tmo_id;

  cam_i2c_arbiter #(.N_REQ(N), .TIMEOUT_CYCLES(TMO), .GAP_CYCLES(GAP)) dut (
    .iCLK(clk), .iRST(rst), .iREQ(req), .iDONE(done), .iSCL_M(scl_m), .iSDA_OE_M(sda_m),
    .oGRANT(grant), .oSCL(scl), .oSDA_OE(sda_oe), .oBUSY(busy), .oTIMEOUT(tmo), .oTIMEOUT_ID(tmo_id)
  );

  always #5 clk = ~clk;

  function automatic logic bit_at(input logic [N-1:0] vec, input int i);
    logic [N-1:0] sh;
    sh = vec >> i;
    return sh[0];
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_owner = -1; m_held = 0; m_gap = 0; m_last = N - 1; m_mask = '0;
    e_grant = '0; e_scl = 1'b1; e_sda = 1'b0; e_busy = 1'b0; e_tmo = 1'b0; e_tmo_id = '0;
  endtask

  // Owner/held-cycles/gap-remaining view of the bus, advanced once per clock edge.
  task automatic model_step();
    logic [N-1:0] nm;
    bit ended, timed, found;
    int g;
    e_tmo = 1'b0; e_scl = 1'b1; e_sda = 1'b0;
    nm = m_mask & req;
    if (m_owner >= 0) begin
      g = m_owner;
      m_held++;
      ended = bit_at(done, g) || !bit_at(req, g);
      timed = !ended && (m_held == TMO);
      if (ended || timed) begin
        if (timed) begin
          e_tmo = 1'b1; e_tmo_id = 3'(g); nm = nm | (N'(1) << g);
        end
        m_owner = -1; m_gap = GAP;
      end else begin
        e_scl = bit_at(scl_m, g); e_sda = bit_at(sda_m, g);
      end
    end else if (m_gap > 0) begin
      m_gap--;
    end else begin
      found = 0;
      for (int k = 1; k <= N; k++) begin
        int j = (m_last + k) % N;
        if (!found && bit_at(req, j) && !bit_at(m_mask, j)) begin
          found = 1; m_owner = j; m_last = j; m_held = 0;
        end
      end
    end
    m_mask  = nm;
    e_grant = (m_owner >= 0) ? N'(1) << m_owner : '0;
    e_busy  = (m_owner >= 0) || (m_gap > 0);
  endtask

  task automatic check_all();
    chk("grant",   32'(grant),  32'(e_grant));
    chk("scl",     32'(scl),    32'(e_scl));
    chk("sda_oe",  32'(sda_oe), 32'(e_sda));
    chk("busy",    32'(busy),   32'(e_busy));
    chk("timeout", 32'(tmo),    32'(e_tmo));
    chk("tmo_id",  32'(tmo_id), 32'(e_tmo_id));
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    cyc++;
    #1;
    check_all();
  endtask

  task automatic wait_grant(input int bound);
    int k = 0;
    while (grant == '0 && k < bound) begin
      tick(); k++;
    end
    chk("grant_seen", 32'(grant != '0), 32'd1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    model_reset();
    #1;
    check_all();
    rst = 1'b0;
  endtask

  initial begin
    #5000000;
    $display("FAIL sim_timeout");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; req = '0; done = '0; scl_m = '1; sda_m = '0;
    model_reset();
    #22;
    check_all();
    @(posedge clk); #1;
    rst = 1'b0;

    // single grant, done after 20 cycles
    req = 3'b010;
    tick();
    chk("single_grant", 32'(grant), 32'h2);
    repeat (19) tick();
    done = 3'b010;
    tick();
    done = '0; req = '0;
    chk("single_release", 32'(grant), 32'h0);
    repeat (4) tick();
    chk("single_busy_low", 32'(busy), 32'h0);
    repeat (3) tick();

    // round robin from reset
    do_reset();
    req = 3'b111;
    for (int r = 0; r < 4; r++) begin
      wait_grant(20);
      chk("rr_order", 32'(grant), 32'(1) << (r % 3));
      repeat (9) begin
        scl_m = 3'($urandom()); sda_m = 3'($urandom());
        tick();
      end
      done = grant;
      tick();
      done = '0;
      n = 0;
      while (grant == '0 && n < 20) begin
        n++; tick();
      end
      chk("rr_gap", 32'(n), 32'd5);
    end
    req = '0; scl_m = '1; sda_m = '0;
    repeat (8) tick();

    // mux isolation
    req = 3'b001; scl_m = 3'b101; sda_m = 3'b010;
    wait_grant(20);
    repeat (12) begin
      v = 1'($urandom());
      scl_m[0] = v;
      tick();
      chk("mux_scl_follow", 32'(scl), 32'(v));
      chk("mux_sda_isolated", 32'(sda_oe), 32'h0);
    end
    req = '0; scl_m = '1; sda_m = '0;
    repeat (8) tick();

    // watchdog revocation of master 2, master 0 waiting
    req = 3'b100;
    wait_grant(20);
    req = 3'b101;
    n = 0;
    while (grant[2] && n < 150) begin
      n++; tick();
    end
    chk("wd_len", 32'(n), 32'd100);
    chk("wd_pulse", 32'(tmo), 32'h1);
    chk("wd_id", 32'(tmo_id), 32'h2);
    wait_grant(10);
    chk("wd_other_granted", 32'(grant), 32'h1);
    done = 3'b001; req = 3'b100;
    tick();
    done = '0;
    repeat (12) tick();
    chk("wd_masked", 32'(grant), 32'h0);
    req = 3'b000;
    tick();
    req = 3'b100;
    wait_grant(10);
    chk("wd_regrant", 32'(grant), 32'h4);
    req = '0;
    repeat (8) tick();

    // done coincident with expiry
    req = 3'b010;
    wait_grant(20);
    repeat (99) tick();
    done = 3'b010;
    tick();
    done = '0;
    chk("coinc_no_timeout", 32'(tmo), 32'h0);
    chk("coinc_release", 32'(grant), 32'h0);
    wait_grant(10);
    chk("coinc_not_masked", 32'(grant), 32'h2);
    req = '0;
    repeat (8) tick();

    // randomized traffic
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < N; i++)
        if ($urandom_range(0, 39) == 0) req[i] = ~req[i];
      done  = ($urandom_range(0, 24) == 0) ? 3'($urandom()) : '0;
      scl_m = 3'($urandom());
      sda_m = 3'($urandom());
      tick();
    end
    req = '0; done = '0; scl_m = '1; sda_m = '0;
    repeat (8) tick();

    // asynchronous reset mid-grant
    req = 3'b001; sda_m = 3'b001;
    wait_grant(20);
    tick();
    chk("pre_reset_sda", 32'(sda_oe), 32'h1);
    #2;
    rst = 1'b1;
    #1;
    chk("async_grant", 32'(grant), 32'h0);
    chk("async_sda", 32'(sda_oe), 32'h0);
    chk("async_scl", 32'(scl), 32'h1);
    @(posedge clk);
    model_reset();
    #1;
    rst = 1'b0;
    req = 3'b011; sda_m = '0;
    tick();
    chk("post_reset_first", 32'(grant), 32'h1);
    req = '0;
    repeat (8) tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/cam_i2c_arbiter.md
# cam_i2c_arbiter

Arbitrates the shared D8M camera I2C bus (CAMERA_I2C_SCL/SDA) between up to N_REQ masters: MIPI bridge configuration, autofocus, and the Nios I2C port. Grants are exclusive and round-robin. Each grant is followed by a mandatory bus-free gap. A watchdog revokes a grant from a master that holds the bus too long. The block sits between the masters' SCL/SDA drivers and the camera bus pad drivers, and replaces the static release-based SCL mux.

## Interface
- N_REQ, 3, number of requesting masters (2..8); index 0 = MIPI config, 1 = autofocus, 2 = Nios
- TIMEOUT_CYCLES, 500000, maximum grant length in iCLK cycles (10 ms at 50 MHz); ≥ 2
- GAP_CYCLES, 250, bus-free cycles after every grant ends (5 µs at 50 MHz); ≥ 1

Ports:
- iCLK  in  1  system clock (CLOCK2_50 domain)
- iRST  in  1  asynchronous, active-high reset
- iREQ  in  N_REQ  level request per master; held high while the master wants the bus
- iDONE  in  N_REQ  1-cycle pulse: the master finished its transaction (STOP issued)
- iSCL_M  in  N_REQ  per-master SCL drive value (0 = pull low, 1 = release)
- iSDA_OE_M  in  N_REQ  per-master SDA output enable (1 = pull low)
- oGRANT  out  N_REQ  one-hot grant; all zero when no master owns the bus
- oSCL  out  1  muxed SCL drive to the pad (1 = released)
- oSDA_OE  out  1  muxed SDA pull-low enable to the pad
- oBUSY  out  1  high in GRANT or GAP
- oTIMEOUT  out  1  1-cycle pulse when a grant is revoked by the watchdog
- oTIMEOUT_ID  out  3  index of the last master revoked by the watchdog; holds its value until the next revocation

## Operation
- States:
  - IDLE: no owner; outputs released.
  - GRANT: owner g; oGRANT[g] = 1; oSCL/oSDA_OE follow master g.
  - GAP: no owner; outputs released; counts GAP_CYCLES, then returns to IDLE.
- Eligibility: eligible = iREQ & ~mask.
- IDLE to GRANT:
  - Taken on any cycle where eligible ≠ 0.
  - Winner is the first eligible index searching upward (with wrap) from last+1.
  - `last` is the most recently granted index; its reset value is N_REQ-1, so index 0 wins first.
- GRANT to GAP, on any of:
  - iDONE[g] = 1
  - iREQ[g] = 0
  - the watchdog expires
- Watchdog:
  - Counter cleared on entry to GRANT, increments every GRANT cycle.
  - Expiry occurs when count = TIMEOUT_CYCLES-1 and no done/req-drop is present in that cycle.
  - On expiry: pulse oTIMEOUT, set oTIMEOUT_ID = g, set mask[g].
- Mask: mask[i] clears when iREQ[i] = 0. A revoked master must drop its request before it can be regranted.
- iDONE on a non-granted index is ignored. iDONE[g] together with iREQ[g] = 1 still ends the grant. A master that keeps requesting re-competes after the gap.
- Mux values are taken from the granted index only. Non-granted masters' SCL/SDA inputs are ignored.
- Counter widths: watchdog uses clog2(TIMEOUT_CYCLES+1) bits; gap counter uses clog2(GAP_CYCLES+1) bits. Neither counter wraps; both saturate at their terminal value.

## Timing
- Reset values:
  - state = IDLE, oGRANT = 0, oSCL = 1, oSDA_OE = 0, oBUSY = 0, oTIMEOUT = 0, oTIMEOUT_ID = 0, mask = 0, last = N_REQ-1.
- Grant latency: iREQ rises in cycle t (IDLE) → oGRANT and oBUSY high at t+1.
- Mux latency: one registered cycle. oSCL/oSDA_OE at cycle n reflect master g's inputs at cycle n-1, only while oGRANT[g] was already high at cycle n-1.
- Grant release: ending event in cycle t → oGRANT = 0, oSCL = 1, oSDA_OE = 0 at t+1. GAP occupies cycles t+1 .. t+GAP_CYCLES.
- Earliest next grant: oGRANT high at t+GAP_CYCLES+2.
- oTIMEOUT is high exactly one cycle, coincident with oGRANT falling.
- Maximum grant length is TIMEOUT_CYCLES cycles of oGRANT high.
- Simultaneous events:
  - done and expiry in the same cycle: done wins; no oTIMEOUT, no mask.
  - A new request during GAP waits; arbitration uses the requests present in the first IDLE cycle.
- Reset asserted mid-GRANT: outputs go to their reset values asynchronously, even if a master is mid-byte.

## Test plan
- Setup for all scenarios: N_REQ=3, TIMEOUT_CYCLES=100, GAP_CYCLES=4.
- Reset and single grant: after reset, iREQ=3'b010 at t → oGRANT=3'b010 at t+1; iDONE[1] at t+20 → oGRANT=0 at t+21, oBUSY=0 at t+25.
- Round-robin fairness: iREQ=3'b111 held; each master pulses iDONE 10 cycles into its grant → grant order 0,1,2,0; 5 idle cycles between grants.
- Mux isolation: grant to 0; master 1 drives iSCL_M[1]=0, iSDA_OE_M[1]=1 → oSCL=1 and oSDA_OE=0 throughout. Master 0 toggling iSCL_M[0] appears on oSCL one cycle later.
- Watchdog: master 2 holds iREQ without iDONE → oGRANT[2] high for exactly 100 cycles, oTIMEOUT pulse, oTIMEOUT_ID=2. Master 2 is not regranted until iREQ[2] drops for ≥1 cycle; master 0 requesting meanwhile is granted after the gap.
- Done coincident with expiry: iDONE[1] in the 100th grant cycle → no oTIMEOUT, mask stays 0.
- Reset mid-grant: iRST asserted while oGRANT=3'b001 and oSDA_OE=1 → oGRANT=0, oSDA_OE=0, oSCL=1 before the next iCLK edge; after release, iREQ=3'b001 is granted first.
